// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro MULDIV_EARLY_OUT_EN ends a multiply early once the remaining multiplier bits are all zero.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     md_q, md_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]     resp_data_q, resp_data_d;

  logic                is_mul;
  logic [XLEN:0]       add_x, add_y;
  logic [XLEN+1:0]     add_res;
  logic [XLEN-1:0]     rem_new;
  logic [2*XLEN-1:0]   prod_step;

  logic                sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [2*XLEN-1:0]   mul_res;
  logic [XLEN-1:0]     quo, rem, fix_res;

  assign req_ready  = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  // Shared adder: multiply adds the multiplicand into the high half; divide
  // subtracts the divisor from the shifted partial remainder, carry-out = no borrow.
  always_comb begin
    is_mul  = !op_q[2];
    add_x   = is_mul ? {1'b0, prod_q[2*XLEN-1:XLEN]} : {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    add_y   = is_mul ? (mplier_q[0] ? {1'b0, md_q} : '0) : ~{1'b0, md_q};
    add_res = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, !is_mul};
    rem_new = add_res[XLEN+1] ? add_res[XLEN-1:0] : add_x[XLEN-1:0];
    if (is_mul) begin
      prod_step = {add_res[XLEN:0], prod_q[XLEN-1:1]};
    end else begin
      prod_step = {rem_new, prod_q[XLEN-2:0], add_res[XLEN+1]};
    end
  end

  always_comb begin
    sgn_a = !(req_op == 3'b011 || req_op == 3'b101 || req_op == 3'b111);
    sgn_b = (req_op == 3'b000 || req_op == 3'b001 || req_op == 3'b100 || req_op == 3'b110);
    neg_a = sgn_a && req_a[XLEN-1];
    neg_b = sgn_b && req_b[XLEN-1];
    mag_a = neg_a ? -req_a : req_a;
    mag_b = neg_b ? -req_b : req_b;

    mul_res = neg_q ? -prod_q : prod_q;
    quo     = prod_q[XLEN-1:0];
    rem     = prod_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = mul_res[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = mul_res[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = neg_q ? -quo : quo;
      default:                fix_res = neg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    neg_d        = neg_q;
    md_d         = md_q;
    mplier_d     = mplier_q;
    prod_d       = prod_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d  = req_op;
          cnt_d = '0;
          if (!req_op[2]) begin
            md_d     = mag_a;
            mplier_d = mag_b;
            prod_d   = '0;
            neg_d    = neg_a ^ neg_b;
            state_d  = CALC;
          end else begin
            md_d     = mag_b;
            mplier_d = '0;
            prod_d   = {{XLEN{1'b0}}, mag_a};
            neg_d    = req_op[1] ? neg_a : (neg_a ^ neg_b);
            if (req_b == '0) begin
              resp_data_d  = req_op[1] ? req_a : '1;
              resp_valid_d = 1'b1;
              state_d      = DONE;
            end else if (!req_op[0] && req_a == MIN_NEG && req_b == '1) begin
              resp_data_d  = req_op[1] ? '0 : MIN_NEG;
              resp_valid_d = 1'b1;
              state_d      = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
      end
      CALC: begin
        cnt_d    = cnt_q + CNT_ONE;
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
        if (cnt_d == CNT_MAX) begin
          state_d = FIXUP;
        end
`ifdef MULDIV_EARLY_OUT_EN
        // Skipped iterations would only shift the product right, so align it in one step.
        else if (is_mul && mplier_d == '0) begin
          prod_d  = prod_step >> (CNT_MAX - cnt_d);
          state_d = FIXUP;
        end
`endif
      end
      FIXUP: begin
        resp_data_d  = fix_res;
        resp_valid_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over accept and over the response handshake; old data stays visible.
    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      neg_q        <= 1'b0;
      md_q         <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      md_q         <= md_d;
      mplier_q     <= mplier_d;
      prod_q       <= prod_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized ops against a 64-bit arithmetic
// reference model, and hand-written backpressure / flush / reset sequences.
module tb_muldiv_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = 3'd0;
  logic [XLEN-1:0] req_a = '0;
  logic [XLEN-1:0] req_b = '0;
  logic            flush = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M semantics straight from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Edges from accept (inclusive) to the first edge after which resp_valid is high.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  task automatic check_latency(input string name, input logic [2:0] op, input int lat, input int exp);
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[2]) begin
      check_output(name, 32'(lat <= exp), 32'd1);
      return;
    end
`endif
    check_output(name, lat, exp);
  endtask

  // Called #1 after an edge with the DUT idle; returns with resp_valid high (or a timeout latency).
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] data, output int lat);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    data = resp_data;
  endtask

  task automatic consume_response();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] data;
    logic [31:0] prev;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic        stable;
    logic        seen;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'd5, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678, 1};
    vecs[14] = '{3'd0, 32'h1234_5678,  32'd0,         32'd0,         34};

    #12;
    check_output("reset_resp_valid", resp_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_resp_data", resp_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("idle_req_ready", req_ready, 1);

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, data, lat);
      check_output($sformatf("vec%0d_data", i), data, vecs[i].exp);
      check_latency($sformatf("vec%0d_latency", i), vecs[i].op, lat, vecs[i].lat);
      consume_response();
    end

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      apply_stimulus(op, a, b, data, lat);
      check_output($sformatf("rand%0d_op%0d_data", i, op), data, ref_model(op, a, b));
      check_latency($sformatf("rand%0d_latency", i), op, lat, ref_latency(op, a, b));
      consume_response();
    end

    // Backpressure: response held for 10 cycles while a competing request waits.
    apply_stimulus(3'd5, 32'd100, 32'd7, data, lat);
    check_output("bp_data", data, 32'd14);
    stable = 1'b1;
    req_op = 3'd0; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!resp_valid || resp_data !== 32'd14 || req_ready) stable = 1'b0;
    end
    req_valid = 1'b0;
    check_output("bp_stable", 32'(stable), 1);
    check_output("bp_busy", busy, 1);
    consume_response();
    check_output("bp_release_valid", resp_valid, 0);
    check_output("bp_release_busy", busy, 0);
    check_output("bp_release_ready", req_ready, 1);
    apply_stimulus(3'd7, 32'd100, 32'd7, data, lat);
    check_output("bp_next_data", data, 32'd2);
    consume_response();
    prev = 32'd2;

    // Flush in CALC cycle 15.
    req_op = 3'd0; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1 flush = 1'b1;
    #1 check_output("flush_req_ready", req_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    check_output("flush_busy", busy, 0);
    check_output("flush_resp_valid", resp_valid, 0);
    check_output("flush_resp_data_kept", resp_data, prev);

    // Flush blocks a simultaneous request.
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd3;
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    check_output("flush_vs_accept_busy", busy, 0);

    // Reset in the middle of CALC.
    req_op = 3'd5; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midreset_busy", busy, 0);
    check_output("midreset_resp_valid", resp_valid, 0);
    check_output("midreset_resp_data", resp_data, 0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check_output("no_response_after_abort", 32'(seen), 0);

    apply_stimulus(3'd3, 32'd3, 32'd5, data, lat);
    check_output("post_reset_mulhu_data", data, 32'd0);
    check_latency("post_reset_mulhu_latency", 3'd3, lat, 34);
    consume_response();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
